// File: rtl/mult_share_arbiter_taint.sv
// mult_share_arbiter_taint
//   Round-robin arbiter/sequencer sharing one sequential multiplier among
//   NREQ requesters, with word-level taint carried through arbitration,
//   handshake and result.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req, req_t               per-requester request and its taint
//   mcand_in, mplier_in      packed operands, requester i at [i*WIDTH +: WIDTH]
//   opnd_t                   per-requester operand taint
//   ack, done                one-cycle grant / result-valid pulses (owner only)
//   done_t                   taint of done (sticky state taint)
//   result, result_t         last delivered product and its taint
//   busy                     high whenever not IDLE
//   mul_start, mul_start_t   start pulse to the multiplier and its taint
//   mul_mcand, mul_mplier    latched operands; mul_opnd_t their taint
//   mul_done, mul_done_t     multiplier productDone and its taint
//   mul_product(_t)          multiplier product and its taint
module mult_share_arbiter_taint #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREQ  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_t,
    input  logic [NREQ*WIDTH-1:0]   mcand_in,
    input  logic [NREQ*WIDTH-1:0]   mplier_in,
    input  logic [NREQ-1:0]         opnd_t,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         done,
    output logic                    done_t,
    output logic [2*WIDTH-1:0]      result,
    output logic                    result_t,
    output logic                    busy,
    output logic                    mul_start,
    output logic                    mul_start_t,
    output logic [WIDTH-1:0]        mul_mcand,
    output logic [WIDTH-1:0]        mul_mplier,
    output logic                    mul_opnd_t,
    input  logic                    mul_done,
    input  logic                    mul_done_t,
    input  logic [2*WIDTH-1:0]      mul_product,
    input  logic                    mul_product_t
);

    localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_e;

    state_e               state_q, state_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        ptr_q, ptr_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 opnd_t_q, opnd_t_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 result_t_q, result_t_d;
    logic                 state_t_q, state_t_d;

    logic [NREQ-1:0][WIDTH-1:0] mcand_arr;
    logic [NREQ-1:0][WIDTH-1:0] mplier_arr;
    logic                 found;
    logic [OW-1:0]        grant_idx;

    assign mcand_arr  = mcand_in;
    assign mplier_arr = mplier_in;

    // Round-robin scan: first set request starting at ptr, wrapping at NREQ.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned   cand;
            logic [OW-1:0] cidx;
            cand = 32'(ptr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            cidx = OW'(cand);
            if (!found && req[cidx]) begin
                found     = 1'b1;
                grant_idx = cidx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        opnd_t_d   = opnd_t_q;
        result_d   = result_q;
        result_t_d = result_t_q;
        state_t_d  = state_t_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d   = grant_idx;
                    mcand_d   = mcand_arr[grant_idx];
                    mplier_d  = mplier_arr[grant_idx];
                    opnd_t_d  = opnd_t[grant_idx];
                    state_t_d = state_t_q | (|req_t);
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                state_t_d = state_t_q | mul_done_t;
                if (mul_done) begin
                    result_d   = mul_product;
                    result_t_d = mul_product_t | opnd_t_q | state_t_q;
                    state_d    = S_DELIVER;
                end
            end
            S_DELIVER: begin
                ptr_d   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            opnd_t_q   <= 1'b0;
            result_q   <= '0;
            result_t_q <= 1'b0;
            state_t_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            opnd_t_q   <= opnd_t_d;
            result_q   <= result_d;
            result_t_q <= result_t_d;
            state_t_q  <= state_t_d;
        end
    end

    // Moore outputs decoded from registered state only.
    always_comb begin
        ack       = '0;
        done      = '0;
        mul_start = 1'b0;
        case (state_q)
            S_ISSUE: begin
                ack[owner_q] = 1'b1;
                mul_start    = 1'b1;
            end
            S_DELIVER: done[owner_q] = 1'b1;
            default: ;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign mul_start_t = state_t_q;
    assign done_t      = state_t_q;
    assign result      = result_q;
    assign result_t    = result_t_q;
    assign mul_mcand   = mcand_q;
    assign mul_mplier  = mplier_q;
    assign mul_opnd_t  = opnd_t_q;

endmodule

// File: tb/tb_mult_share_arbiter_taint.sv
// tb_mult_share_arbiter_taint
//   Scoreboard bench for mult_share_arbiter_taint (WIDTH=4, NREQ=3) with a
//   behavioural sequential multiplier of fixed latency.
module tb_mult_share_arbiter_taint;

    localparam int unsigned W = 4;
    localparam int unsigned N = 3;
    localparam int unsigned M = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req, req_t, opnd_t;
    logic [N*W-1:0]     mcand_in, mplier_in;
    logic [N-1:0]       ack, done;
    logic               done_t, result_t, busy, mul_start, mul_start_t, mul_opnd_t;
    logic [2*W-1:0]     result, mul_product;
    logic [W-1:0]       mul_mcand, mul_mplier;
    logic               mul_done, mul_done_t, mul_product_t;

    mult_share_arbiter_taint #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst(rst), .req(req), .req_t(req_t),
        .mcand_in(mcand_in), .mplier_in(mplier_in), .opnd_t(opnd_t),
        .ack(ack), .done(done), .done_t(done_t), .result(result),
        .result_t(result_t), .busy(busy), .mul_start(mul_start),
        .mul_start_t(mul_start_t), .mul_mcand(mul_mcand), .mul_mplier(mul_mplier),
        .mul_opnd_t(mul_opnd_t), .mul_done(mul_done), .mul_done_t(mul_done_t),
        .mul_product(mul_product), .mul_product_t(mul_product_t)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned  idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ot;
        logic         st;
    } ack_exp_t;

    typedef struct {
        int unsigned    idx;
        logic [2*W-1:0] res;
        logic           rt;
        logic           dt;
    } done_exp_t;

    ack_exp_t    ackq[$];
    done_exp_t   doneq[$];
    ack_exp_t    ae;
    done_exp_t   de;
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned done_drive_cyc = 0;
    int unsigned n_starts = 0;
    int unsigned n_grants = 0;
    int unsigned hold [N];

    logic           m_busy;
    int unsigned    m_cnt;
    logic [W-1:0]   m_a, m_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ot, input logic rt);
        mcand_in[i*W +: W]  = a;
        mplier_in[i*W +: W] = b;
        opnd_t[i]           = ot;
        req_t[i]            = rt;
        req[i]              = 1'b1;
    endtask

    task automatic expect_ack(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ot, input logic st);
        ack_exp_t e;
        e.idx = i; e.a = a; e.b = b; e.ot = ot; e.st = st;
        ackq.push_back(e);
        n_grants++;
    endtask

    task automatic expect_txn(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ot, input logic st, input logic [2*W-1:0] res,
                              input logic rt, input logic dt);
        done_exp_t d;
        expect_ack(i, a, b, ot, st);
        d.idx = i; d.res = res; d.rt = rt; d.dt = dt;
        doneq.push_back(d);
    endtask

    task automatic wait_quiet(input string name);
        int k = 0;
        while (k < 200 && (busy || req != '0 || ackq.size() != 0 || doneq.size() != 0)) begin
            @(negedge clk); #1;
            k++;
        end
        check({"quiet_", name}, 64'(k >= 200), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural multiplier: latches operands on the start pulse and raises
    // productDone for one cycle M cycles later.
    initial begin
        mul_done = 1'b0; mul_done_t = 1'b0; mul_product = '0; mul_product_t = 1'b0;
        m_busy = 1'b0; m_cnt = 0; m_a = '0; m_b = '0;
        forever begin
            @(posedge clk); #1;
            mul_done = 1'b0;
            if (rst) begin
                m_busy = 1'b0;
            end else if (mul_start && !m_busy) begin
                m_busy = 1'b1; m_cnt = M; m_a = mul_mcand; m_b = mul_mplier;
            end else if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    mul_product    = {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
                    mul_done       = 1'b1;
                    m_busy         = 1'b0;
                    done_drive_cyc = cyc;
                end
            end
        end
    end

    // Requester side: drop req the cycle after ack unless asked to hold it.
    initial begin
        for (int i = 0; i < N; i++) hold[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    if (hold[i] > 0) hold[i]--;
                    else begin
                        req[i]   = 1'b0;
                        req_t[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents ack or done.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (mul_start) n_starts++;
            if (|ack) begin
                if (ackq.size() == 0) check("unexpected_ack", 64'(ack), 64'(0));
                else begin
                    ae = ackq.pop_front();
                    check("ack_onehot", 64'(ack), 64'(N'(1) << ae.idx));
                    check("start_with_ack", 64'(mul_start), 64'(1));
                    check("mul_mcand", 64'(mul_mcand), 64'(ae.a));
                    check("mul_mplier", 64'(mul_mplier), 64'(ae.b));
                    check("mul_opnd_t", 64'(mul_opnd_t), 64'(ae.ot));
                    check("mul_start_t", 64'(mul_start_t), 64'(ae.st));
                end
            end
            if (|done) begin
                if (doneq.size() == 0) check("unexpected_done", 64'(done), 64'(0));
                else begin
                    de = doneq.pop_front();
                    check("done_onehot", 64'(done), 64'(N'(1) << de.idx));
                    check("result", 64'(result), 64'(de.res));
                    check("result_t", 64'(result_t), 64'(de.rt));
                    check("done_t", 64'(done_t), 64'(de.dt));
                    check("done_latency", 64'(cyc), 64'(done_drive_cyc + 1));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; req_t = '0; opnd_t = '0; mcand_in = '0; mplier_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({ack, done, done_t, result, result_t, busy, mul_start,
              mul_start_t, mul_mcand, mul_mplier, mul_opnd_t}), 64'(0));
        rst = 1'b0;
        #1;

        // Single request, with grant one cycle after req rises.
        set_req(0, 4'd3, 4'd5, 1'b0, 1'b0);
        expect_txn(0, 4'd3, 4'd5, 1'b0, 1'b0, 8'd15, 1'b0, 1'b0);
        @(negedge clk);
        check("ack_latency", 64'(ack), 64'(3'b001));
        wait_quiet("single");

        // Simultaneous pair from reset, then repeated pair.
        do_reset();
        set_req(0, 4'd2, 4'd7, 1'b0, 1'b0);
        set_req(1, 4'd6, 4'd6, 1'b0, 1'b0);
        expect_txn(0, 4'd2, 4'd7, 1'b0, 1'b0, 8'd14, 1'b0, 1'b0);
        expect_txn(1, 4'd6, 4'd6, 1'b0, 1'b0, 8'd36, 1'b0, 1'b0);
        wait_quiet("pair1");
        set_req(0, 4'd2, 4'd7, 1'b0, 1'b0);
        set_req(1, 4'd6, 4'd6, 1'b0, 1'b0);
        expect_txn(0, 4'd2, 4'd7, 1'b0, 1'b0, 8'd14, 1'b0, 1'b0);
        expect_txn(1, 4'd6, 4'd6, 1'b0, 1'b0, 8'd36, 1'b0, 1'b0);
        wait_quiet("pair2");

        // All three from reset, including the maximum product.
        do_reset();
        set_req(0, 4'd15, 4'd15, 1'b0, 1'b0);
        set_req(1, 4'd12, 4'd13, 1'b0, 1'b0);
        set_req(2, 4'd9,  4'd4,  1'b0, 1'b0);
        expect_txn(0, 4'd15, 4'd15, 1'b0, 1'b0, 8'd225, 1'b0, 1'b0);
        expect_txn(1, 4'd12, 4'd13, 1'b0, 1'b0, 8'd156, 1'b0, 1'b0);
        expect_txn(2, 4'd9,  4'd4,  1'b0, 1'b0, 8'd36,  1'b0, 1'b0);
        wait_quiet("triple");

        // Pointer rotation: after serving 1, requester 2 outranks 0.
        set_req(1, 4'd4, 4'd4, 1'b0, 1'b0);
        expect_txn(1, 4'd4, 4'd4, 1'b0, 1'b0, 8'd16, 1'b0, 1'b0);
        wait_quiet("rot1");
        set_req(0, 4'd5, 4'd2, 1'b0, 1'b0);
        set_req(2, 4'd3, 4'd3, 1'b0, 1'b0);
        expect_txn(2, 4'd3, 4'd3, 1'b0, 1'b0, 8'd9,  1'b0, 1'b0);
        expect_txn(0, 4'd5, 4'd2, 1'b0, 1'b0, 8'd10, 1'b0, 1'b0);
        wait_quiet("rot2");

        // Operand taint affects only its own transaction.
        set_req(0, 4'd7, 4'd3, 1'b1, 1'b0);
        expect_txn(0, 4'd7, 4'd3, 1'b1, 1'b0, 8'd21, 1'b1, 1'b0);
        wait_quiet("opnd_t");
        set_req(1, 4'd2, 4'd2, 1'b0, 1'b0);
        expect_txn(1, 4'd2, 4'd2, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0);
        wait_quiet("opnd_t_clean");

        // Spurious productDone while idle.
        @(negedge clk);
        mul_done = 1'b1;
        @(negedge clk);
        check("spurious_busy", 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
        check("spurious_idle", 64'({busy, result, result_t}), 64'({1'b0, 8'd4, 1'b0}));

        // Reset during WAIT aborts; pointer returns to 0.
        set_req(0, 4'd5, 4'd5, 1'b0, 1'b0);
        expect_ack(0, 4'd5, 4'd5, 1'b0, 1'b0);
        for (int k = 0; k < 20 && ackq.size() != 0; k++) begin
            @(negedge clk); #1;
        end
        check("abort_ack_seen", 64'(ackq.size()), 64'(0));
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort_outputs", 64'({ack, done, done_t, result, result_t, busy, mul_start,
              mul_start_t, mul_mcand, mul_mplier, mul_opnd_t}), 64'(0));
        @(posedge clk); #3;
        rst = 1'b0;
        set_req(0, 4'd5, 4'd3, 1'b0, 1'b0);
        set_req(2, 4'd4, 4'd7, 1'b0, 1'b0);
        expect_txn(0, 4'd5, 4'd3, 1'b0, 1'b0, 8'd15, 1'b0, 1'b0);
        expect_txn(2, 4'd4, 4'd7, 1'b0, 1'b0, 8'd28, 1'b0, 1'b0);
        wait_quiet("after_abort");

        // Request taint sets sticky state taint.
        set_req(1, 4'd3, 4'd4, 1'b0, 1'b1);
        expect_txn(1, 4'd3, 4'd4, 1'b0, 1'b1, 8'd12, 1'b1, 1'b1);
        wait_quiet("req_t");
        set_req(0, 4'd1, 4'd2, 1'b0, 1'b0);
        expect_txn(0, 4'd1, 4'd2, 1'b0, 1'b1, 8'd2, 1'b1, 1'b1);
        wait_quiet("sticky");

        // req held through DELIVER is granted again.
        hold[2] = 1;
        set_req(2, 4'd2, 4'd3, 1'b0, 1'b0);
        expect_txn(2, 4'd2, 4'd3, 1'b0, 1'b1, 8'd6, 1'b1, 1'b1);
        expect_txn(2, 4'd2, 4'd3, 1'b0, 1'b1, 8'd6, 1'b1, 1'b1);
        wait_quiet("held_req");

        check("start_count", 64'(n_starts), 64'(n_grants));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
